// File: rtl/dwt_pkg.sv
// Shared types and address helpers for the lifting-wavelet scheduler.
package dwt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW_RD,
    ST_ROW_DRAIN,
    ST_COL_RD,
    ST_COL_DRAIN,
    ST_DONE
  } state_e;

  localparam logic BAND_L   = 1'b0;
  localparam logic BAND_H   = 1'b1;
  localparam logic PASS_ROW = 1'b0;
  localparam logic PASS_COL = 1'b1;

  // Position inside a segment after the even/odd split: L half first, H half second.
  function automatic int band_pos(int k, int half);
    return ((k & 1) != 0) ? half + (k >> 1) : (k >> 1);
  endfunction

  function automatic int src_addr(int k, int m, logic pass, int w);
    return (pass == PASS_COL) ? k * w + m : m * w + k;
  endfunction

  function automatic int row_dst(int k, int m, int w);
    return m * w + band_pos(k, w / 2);
  endfunction

  function automatic int col_dst(int k, int m, int w, int h);
    return band_pos(k, h / 2) * w + m;
  endfunction

endpackage

// File: rtl/dwt_sched_delay.sv
// Stall-holdable shift register that carries the write tag alongside the datapath.
module dwt_sched_delay #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] stage_q [DEPTH];
  logic [DW-1:0] stage_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
    if (en) begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/dwt_lift_sched.sv
// Row-then-column read/write sequencer for the 2-D lifting wavelet datapath.
//   state        | meaning
//   ST_IDLE      | waiting for start
//   ST_ROW_RD    | row-major reads, one per cycle
//   ST_ROW_DRAIN | PIPE_LAT cycles letting row-pass writes land
//   ST_COL_RD    | column-major reads, one per cycle
//   ST_COL_DRAIN | PIPE_LAT cycles letting column-pass writes land
//   ST_DONE      | one-cycle done pulse
module dwt_lift_sched
  import dwt_pkg::*;
#(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int ADDR_W   = 6,
  parameter int PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bank,
  output logic              phase,
  output logic              seg_first,
  output logic              seg_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_band
);

  localparam int TW    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int TAG_W = 2 + 2 * ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] m_q, m_d;
  logic [TW-1:0]     tmr_q, tmr_d;

  logic              rd_st;
  logic              col_st;
  logic [ADDR_W-1:0] seg_end;
  logic [ADDR_W-1:0] line_end;
  logic              k_at_end;
  logic              m_at_end;

  logic [TAG_W-1:0]  tag_in;
  logic [TAG_W-1:0]  tag_out;
  logic              t_valid;
  logic              t_pass;
  logic [ADDR_W-1:0] t_k;
  logic [ADDR_W-1:0] t_m;

  assign rd_st    = (state_q == ST_ROW_RD) || (state_q == ST_COL_RD);
  assign col_st   = (state_q == ST_COL_RD) || (state_q == ST_COL_DRAIN) || (state_q == ST_DONE);
  assign seg_end  = col_st ? ADDR_W'(IMG_H - 1) : ADDR_W'(IMG_W - 1);
  assign line_end = col_st ? ADDR_W'(IMG_W - 1) : ADDR_W'(IMG_H - 1);
  assign k_at_end = (k_q == seg_end);
  assign m_at_end = (m_q == line_end);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    m_d     = m_q;
    tmr_d   = tmr_q;
    if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_ROW_RD;
        end
        ST_ROW_RD, ST_COL_RD: begin
          if (k_at_end) begin
            k_d = '0;
            if (m_at_end) begin
              m_d     = '0;
              tmr_d   = TW'(PIPE_LAT - 1);
              state_d = (state_q == ST_ROW_RD) ? ST_ROW_DRAIN : ST_COL_DRAIN;
            end else begin
              m_d = m_q + ADDR_W'(1);
            end
          end else begin
            k_d = k_q + ADDR_W'(1);
          end
        end
        ST_ROW_DRAIN, ST_COL_DRAIN: begin
          if (tmr_q == '0) begin
            state_d = (state_q == ST_ROW_DRAIN) ? ST_COL_RD : ST_DONE;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      m_q     <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      m_q     <= m_d;
      tmr_q   <= tmr_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  // Gated so a stall landing on ST_DONE cannot stretch the pulse.
  assign done      = (state_q == ST_DONE) && !stall;
  assign pass      = col_st;
  assign rd_bank   = col_st;
  assign rd_en     = rd_st && !stall;
  assign rd_addr   = ADDR_W'(src_addr(int'(k_q), int'(m_q), col_st, IMG_W));
  assign phase     = k_q[0];
  assign seg_first = rd_st && (k_q == '0);
  assign seg_last  = rd_st && k_at_end;

  assign tag_in = {rd_en, col_st, k_q, m_q};

  dwt_sched_delay #(
    .DEPTH (PIPE_LAT),
    .DW    (TAG_W)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .en  (!stall),
    .d   (tag_in),
    .q   (tag_out)
  );

  assign t_valid = tag_out[TAG_W-1];
  assign t_pass  = tag_out[TAG_W-2];
  assign t_k     = tag_out[2*ADDR_W-1:ADDR_W];
  assign t_m     = tag_out[ADDR_W-1:0];

  assign wr_en   = t_valid && !stall;
  assign wr_band = t_k[0];
  assign wr_addr = (t_pass == PASS_COL)
                 ? ADDR_W'(col_dst(int'(t_k), int'(t_m), IMG_W, IMG_H))
                 : ADDR_W'(row_dst(int'(t_k), int'(t_m), IMG_W));

endmodule

// File: tb/tb_dwt_lift_sched.sv
// Randomized/directed bench for dwt_lift_sched against a queue-based reference of read/write order.
module tb_dwt_lift_sched;

  typedef struct {
    int addr;
    int ph;
    int fi;
    int la;
  } rd_t;

  typedef struct {
    int addr;
    int band;
  } wr_t;

  logic clk = 1'b0;
  logic rst, start_b, start_s, stall;
  bit   sel;

  logic       b_busy, b_done, b_pass, b_rd_en, b_rd_bank, b_phase, b_seg_first, b_seg_last;
  logic       b_wr_en, b_wr_band;
  logic [5:0] b_rd_addr, b_wr_addr;
  logic       s_busy, s_done, s_pass, s_rd_en, s_rd_bank, s_phase, s_seg_first, s_seg_last;
  logic       s_wr_en, s_wr_band;
  logic [2:0] s_rd_addr, s_wr_addr;

  int m_busy, m_done, m_rd_en, m_rd_addr, m_phase, m_first, m_last, m_wr_en, m_wr_addr, m_band;
  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  dwt_lift_sched #(.IMG_W(8), .IMG_H(8), .ADDR_W(6), .PIPE_LAT(4)) dut (
    .clk(clk), .rst(rst), .start(start_b), .stall(stall),
    .busy(b_busy), .done(b_done), .pass(b_pass), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_bank(b_rd_bank), .phase(b_phase), .seg_first(b_seg_first), .seg_last(b_seg_last),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_band(b_wr_band)
  );

  dwt_lift_sched #(.IMG_W(4), .IMG_H(2), .ADDR_W(3), .PIPE_LAT(1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .stall(stall),
    .busy(s_busy), .done(s_done), .pass(s_pass), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .rd_bank(s_rd_bank), .phase(s_phase), .seg_first(s_seg_first), .seg_last(s_seg_last),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_band(s_wr_band)
  );

  always_comb begin
    m_busy    = sel ? int'(s_busy)      : int'(b_busy);
    m_done    = sel ? int'(s_done)      : int'(b_done);
    m_rd_en   = sel ? int'(s_rd_en)     : int'(b_rd_en);
    m_rd_addr = sel ? int'(s_rd_addr)   : int'(b_rd_addr);
    m_phase   = sel ? int'(s_phase)     : int'(b_phase);
    m_first   = sel ? int'(s_seg_first) : int'(b_seg_first);
    m_last    = sel ? int'(s_seg_last)  : int'(b_seg_last);
    m_wr_en   = sel ? int'(s_wr_en)     : int'(b_wr_en);
    m_wr_addr = sel ? int'(s_wr_addr)   : int'(b_wr_addr);
    m_band    = sel ? int'(s_wr_band)   : int'(b_wr_band);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_s = v;
    else     start_b = v;
  endtask

  // smode: 0 no stall, 1 stall cycles 20..22, 2 random stalls. Enter and leave #1 after a posedge.
  task automatic run(input int w, input int h, input int pl, input int smode,
                     input bit poke, input bit directed);
    rd_t rq[$];
    wr_t wq[$];
    rd_t re;
    wr_t we;
    int  base, stalls, done_cyc, n_rd, n_wr, first_rd, first_wr, col_start, cyc;

    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        rq.push_back(rd_t'{r*w + c, c % 2, int'(c == 0), int'(c == w-1)});
        wq.push_back(wr_t'{r*w + ((c % 2 == 1) ? w/2 + c/2 : c/2), c % 2});
      end
    for (int c = 0; c < w; c++)
      for (int r = 0; r < h; r++) begin
        rq.push_back(rd_t'{r*w + c, r % 2, int'(r == 0), int'(r == h-1)});
        wq.push_back(wr_t'{((r % 2 == 1) ? h/2 + r/2 : r/2)*w + c, r % 2});
      end

    base = 2*(w*h + pl) + 1;
    stalls = 0; done_cyc = -1; n_rd = 0; n_wr = 0;
    first_rd = -1; first_wr = -1; col_start = -1;

    stall = 1'b0;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);

    cyc = 1;
    while (cyc <= base + stalls + 1) begin
      if (smode == 1)      stall = (cyc >= 20 && cyc <= 22);
      else if (smode == 2) stall = (cyc >= 2 && cyc <= base - 10) && ($urandom_range(0, 3) == 0);
      else                 stall = 1'b0;
      if (stall) stalls++;
      set_start(poke && cyc >= 10 && cyc <= 12);
      @(negedge clk);
      if (stall) begin
        chk("stall_rd_en", m_rd_en, 0);
        chk("stall_wr_en", m_wr_en, 0);
      end
      if (m_rd_en != 0) begin
        if (rq.size() == 0) chk("rd_extra", n_rd, 2*w*h - 1);
        else begin
          re = rq.pop_front();
          chk("rd_addr", m_rd_addr, re.addr);
          chk("phase", m_phase, re.ph);
          chk("seg_first", m_first, re.fi);
          chk("seg_last", m_last, re.la);
        end
        if (first_rd < 0) first_rd = cyc;
        if (n_rd == w*h) col_start = cyc;
        n_rd++;
      end
      if (m_wr_en != 0) begin
        if (wq.size() == 0) chk("wr_extra", n_wr, 2*w*h - 1);
        else begin
          we = wq.pop_front();
          chk("wr_addr", m_wr_addr, we.addr);
          chk("wr_band", m_band, we.band);
        end
        if (first_wr < 0) first_wr = cyc;
        n_wr++;
      end
      if (m_done != 0) begin
        if (done_cyc < 0) done_cyc = cyc;
        else chk("done_twice", cyc, done_cyc);
      end
      if (cyc == 1)               chk("busy_rise", m_busy, 1);
      if (cyc == base + stalls)   chk("busy_at_done", m_busy, 1);
      if (cyc == base + stalls + 1) chk("busy_fall", m_busy, 0);
      @(posedge clk); #1;
      cyc++;
    end
    stall = 1'b0;
    set_start(1'b0);

    chk("done_cycle", done_cyc, base + stalls);
    chk("rd_left", rq.size(), 0);
    chk("wr_left", wq.size(), 0);
    chk("n_rd", n_rd, 2*w*h);
    chk("n_wr", n_wr, 2*w*h);
    if (directed) begin
      chk("first_rd_cyc", first_rd, 1);
      chk("first_wr_cyc", first_wr, 1 + pl);
      chk("col_start_cyc", col_start, w*h + pl + 1);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic abort_run();
    sel = 1'b0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    chk("abort_pre_busy", int'(b_busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(b_busy), 0);
    chk("abort_done", int'(b_done), 0);
    chk("abort_pass", int'(b_pass), 0);
    chk("abort_rd_en", int'(b_rd_en), 0);
    chk("abort_rd_addr", int'(b_rd_addr), 0);
    chk("abort_phase", int'(b_phase), 0);
    chk("abort_first", int'(b_seg_first), 0);
    chk("abort_wr_en", int'(b_wr_en), 0);
    chk("abort_wr_addr", int'(b_wr_addr), 0);
    chk("abort_wr_band", int'(b_wr_band), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", int'(b_done), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_idle", int'(b_busy), 0);
      chk("post_abort_done", int'(b_done), 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start_b = 1'b0; start_s = 1'b0; stall = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_b_busy", int'(b_busy), 0);
    chk("rst_b_rd_en", int'(b_rd_en), 0);
    chk("rst_b_wr_en", int'(b_wr_en), 0);
    chk("rst_b_rd_addr", int'(b_rd_addr), 0);
    chk("rst_b_pass", int'(b_pass), 0);
    chk("rst_b_bank", int'(b_rd_bank), 0);
    chk("rst_s_busy", int'(s_busy), 0);
    chk("rst_s_wr_addr", int'(s_wr_addr), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(8, 8, 4, 0, 1'b0, 1'b1);
    run(8, 8, 4, 1, 1'b0, 1'b0);
    run(8, 8, 4, 0, 1'b1, 1'b0);
    abort_run();
    run(8, 8, 4, 0, 1'b0, 1'b1);

    sel = 1'b1;
    run(4, 2, 1, 0, 1'b0, 1'b1);
    run(4, 2, 1, 2, 1'b0, 1'b0);
    sel = 1'b0;
    run(8, 8, 4, 2, 1'b1, 1'b0);
    run(8, 8, 4, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
